// File: rtl/l2_line_responder_pkg.sv
// Shared types and default sizes for the L2 line responder.
//   DEF_LINE_SIZE  : cache line width in bits
//   DEF_BUS_WIDTH  : backing-memory beat width in bits
//   ADDR_WIDTH     : address width on both the L1 and backing-memory sides
//   resp_state_t   : responder FSM states
package l2_line_responder_pkg;

  localparam int DEF_LINE_SIZE = 512;
  localparam int DEF_BUS_WIDTH = 128;
  localparam int ADDR_WIDTH    = 64;

  typedef enum logic [1:0] {
    RESP_IDLE,
    RESP_XFER,
    RESP_RESPOND,
    RESP_TURN
  } resp_state_t;

endpackage

// File: rtl/l2_line_responder_if.sv
// Handshake bundle between the L1 line-request side, the responder and the
// backing-memory beat bus. The wide bidirectional mem_data line stays a plain
// port of the responder because it is a tristate net.
//   L1 side  : mem_req_load, mem_req_store, mem_addr (to responder), mem_ready (from)
//   Bus side : bus_req, bus_we, bus_addr, bus_wdata (from responder),
//              bus_rdata, bus_ack (to responder)
// Modports: slave = the responder, master = the surrounding L1/memory environment.
interface l2_line_responder_if
  import l2_line_responder_pkg::*;
#(
  parameter int MEM_BUS_WIDTH = DEF_BUS_WIDTH
) ();

  logic                     mem_req_load;
  logic                     mem_req_store;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic                     mem_ready;

  logic                     bus_req;
  logic                     bus_we;
  logic [ADDR_WIDTH-1:0]    bus_addr;
  logic [MEM_BUS_WIDTH-1:0] bus_wdata;
  logic [MEM_BUS_WIDTH-1:0] bus_rdata;
  logic                     bus_ack;

  modport slave (
    input  mem_req_load, mem_req_store, mem_addr, bus_rdata, bus_ack,
    output mem_ready, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport master (
    output mem_req_load, mem_req_store, mem_addr, bus_rdata, bus_ack,
    input  mem_ready, bus_req, bus_we, bus_addr, bus_wdata
  );

endinterface

// File: rtl/l2_line_responder.sv
// Memory-side responder for L1 line requests. Accepts a whole-line load
// (refill) or store (write-back), moves the line over the narrower backing
// bus one beat at a time (beat 0 = lowest address), then pulses mem_ready
// for one cycle, followed by one turnaround cycle.
// Ports:
//   clock    : posedge clock
//   reset    : asynchronous active-low reset
//   mem_data : line data; sampled from L1 on a store, driven to L1 only in
//              the mem_ready cycle of a load, high-Z otherwise
//   io       : l2_line_responder_if.slave (L1 request/ready + beat bus)
module l2_line_responder
  import l2_line_responder_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = DEF_LINE_SIZE,
  parameter int MEM_BUS_WIDTH   = DEF_BUS_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  inout  wire  [CACHE_LINE_SIZE-1:0] mem_data,
  l2_line_responder_if.slave         io
);

  localparam int BEATS      = CACHE_LINE_SIZE / MEM_BUS_WIDTH;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_BYTES = MEM_BUS_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(CACHE_LINE_SIZE / 8 - 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);

  resp_state_t                state_q, state_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic                       op_store_q, op_store_d;
  logic [ADDR_WIDTH-1:0]      line_addr_q, line_addr_d;
  logic [CACHE_LINE_SIZE-1:0] line_buf;
  logic                       accept;
  logic                       beat_done;
  logic                       in_xfer;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    op_store_d  = op_store_q;
    line_addr_d = line_addr_q;
    accept      = 1'b0;
    beat_done   = 1'b0;

    unique case (state_q)
      RESP_IDLE: begin
        if (io.mem_req_store || io.mem_req_load) begin
          accept      = 1'b1;
          // A write-back wins when both requests arrive together.
          op_store_d  = io.mem_req_store;
          line_addr_d = io.mem_addr & ~LINE_MASK;
          beat_d      = '0;
          state_d     = RESP_XFER;
        end
      end
      RESP_XFER: begin
        if (io.bus_ack) begin
          beat_done = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = RESP_RESPOND;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      RESP_RESPOND: state_d = RESP_TURN;
      // The L1 drops its request one cycle after seeing mem_ready; this
      // cycle keeps that stale request from being taken as a new one.
      RESP_TURN:    state_d = RESP_IDLE;
      default:      state_d = RESP_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RESP_IDLE;
      beat_q      <= '0;
      op_store_q  <= 1'b0;
      line_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      op_store_q  <= op_store_d;
      line_addr_q <= line_addr_d;
    end
  end

  // NOTE: the line buffer is pure data storage and is left out of reset;
  // nothing observes it before a request has filled it.
  always_ff @(posedge clock) begin
    if (accept && io.mem_req_store) begin
      line_buf <= mem_data;
    end else if (beat_done && !op_store_q) begin
      line_buf[beat_q*MEM_BUS_WIDTH +: MEM_BUS_WIDTH] <= io.bus_rdata;
    end
  end

  // All outputs decode the state flops only, so reset takes effect on them
  // immediately and bus_ack has no combinational path to mem_ready.
  assign in_xfer      = (state_q == RESP_XFER);
  assign io.bus_req   = in_xfer;
  assign io.bus_we    = in_xfer && op_store_q;
  assign io.bus_addr  = in_xfer ? line_addr_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BEAT_BYTES)
                                : '0;
  assign io.bus_wdata = (in_xfer && op_store_q)
                        ? line_buf[beat_q*MEM_BUS_WIDTH +: MEM_BUS_WIDTH] : '0;
  assign io.mem_ready = (state_q == RESP_RESPOND);

  assign mem_data = (state_q == RESP_RESPOND && !op_store_q)
                    ? line_buf : {CACHE_LINE_SIZE{1'bz}};

endmodule

// File: tb/tb_l2_line_responder.sv
`timescale 1ns/1ps
module tb_l2_line_responder;
  import l2_line_responder_pkg::*;

  localparam int LW    = DEF_LINE_SIZE;
  localparam int BW    = DEF_BUS_WIDTH;
  localparam int BEATS = LW / BW;
  localparam int BB    = BW / 8;
  localparam int LB    = LW / 8;

  typedef struct {
    logic          we;
    logic [63:0]   addr;
    logic [BW-1:0] wdata;
  } beat_t;

  typedef struct {
    logic          is_load;
    logic [LW-1:0] data;
    bit            timed;
    int            issue_cyc;
    int            stall_base;
  } resp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  wire  [LW-1:0] mem_data;
  logic [LW-1:0] tb_drv;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_total = 0;
  int stall_left = 0;
  logic [63:0] stall_addr = '0;
  bit random_ack = 1'b0;

  beat_t exp_beats[$];
  resp_t exp_resp[$];
  logic [BW-1:0] bmem    [logic [63:0]];
  logic [BW-1:0] ref_mem [logic [63:0]];

  l2_line_responder_if #(.MEM_BUS_WIDTH(BW)) io ();

  l2_line_responder #(.CACHE_LINE_SIZE(LW), .MEM_BUS_WIDTH(BW)) dut (
    .clock    (clock),
    .reset    (reset),
    .mem_data (mem_data),
    .io       (io)
  );

  // The L1 side drives mem_data at all times except the mem_ready cycle.
  assign mem_data = io.mem_ready ? {LW{1'bz}} : tb_drv;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not allowed here (cycle %0d)", name, cyc);
  endtask

  function automatic logic [BW-1:0] init_word(input logic [63:0] a);
    return {4{a[31:0] ^ 32'h5A3C_96E1}};
  endfunction

  function automatic logic [BW-1:0] bmem_rd(input logic [63:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  function automatic logic [BW-1:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: a line request touches the aligned line containing
  // addr, lowest beat first; a store updates memory, a load returns it.
  task automatic push_expect(input bit is_store, input logic [63:0] addr,
                             input logic [LW-1:0] data, input bit timed);
    logic [63:0] line;
    beat_t b;
    resp_t r;
    line         = addr - (addr % LB);
    r.is_load    = !is_store;
    r.data       = '0;
    r.timed      = timed;
    r.issue_cyc  = cyc;
    r.stall_base = stall_total;
    for (int i = 0; i < BEATS; i++) begin
      b.we    = is_store;
      b.addr  = line + 64'(i * BB);
      b.wdata = is_store ? data[i*BW +: BW] : '0;
      exp_beats.push_back(b);
      if (is_store) ref_mem[b.addr] = data[i*BW +: BW];
      else          r.data[i*BW +: BW] = ref_rd(b.addr);
    end
    exp_resp.push_back(r);
  endtask

  // Backing memory plus beat monitor, evaluated mid-cycle.
  beat_t dev_b, hold_b;
  bit    hold_valid = 1'b0;
  bit    ack;
  always @(negedge clock) begin
    if (!reset) begin
      hold_valid   = 1'b0;
      io.bus_ack   = 1'b0;
      io.bus_rdata = '0;
    end else if (io.bus_req) begin
      if (hold_valid) begin
        check("hold_addr",  io.bus_addr,  hold_b.addr);
        check("hold_we",    io.bus_we,    hold_b.we);
        check("hold_wdata", io.bus_wdata, hold_b.wdata);
      end
      if (stall_left > 0 && io.bus_addr == stall_addr) begin
        ack = 1'b0;
        stall_left--;
      end else if (random_ack) begin
        ack = ($urandom_range(0, 3) != 0);
      end else begin
        ack = 1'b1;
      end
      io.bus_ack   = ack;
      io.bus_rdata = bmem_rd(io.bus_addr);
      if (ack) begin
        hold_valid = 1'b0;
        if (exp_beats.size() == 0) begin
          fail("unexpected_beat");
        end else begin
          dev_b = exp_beats.pop_front();
          check("beat_addr", io.bus_addr, dev_b.addr);
          check("beat_we",   io.bus_we,   dev_b.we);
          if (dev_b.we) check("beat_wdata", io.bus_wdata, dev_b.wdata);
        end
        if (io.bus_we) bmem[io.bus_addr] = io.bus_wdata;
      end else begin
        stall_total++;
        hold_valid = 1'b1;
        hold_b.we    = io.bus_we;
        hold_b.addr  = io.bus_addr;
        hold_b.wdata = io.bus_wdata;
      end
    end else begin
      if (hold_valid) fail("bus_req_dropped_before_ack");
      hold_valid = 1'b0;
      io.bus_ack = 1'b0;
    end
  end

  // Response monitor.
  resp_t mon_r;
  bit    prev_ready = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      if (!io.mem_ready) begin
        check("mem_data_released", mem_data, tb_drv);
      end else begin
        if (prev_ready) fail("ready_wider_than_one_cycle");
        if (exp_resp.size() == 0) begin
          fail("unexpected_ready");
        end else begin
          mon_r = exp_resp.pop_front();
          if (mon_r.is_load) check("load_data", mem_data, mon_r.data);
          if (mon_r.timed)
            check("ready_latency", cyc,
                  mon_r.issue_cyc + 1 + BEATS + (stall_total - mon_r.stall_base));
        end
      end
      prev_ready = io.mem_ready;
    end else begin
      if (io.mem_ready) fail("ready_during_reset");
      prev_ready = 1'b0;
    end
  end

  task automatic wait_ready(output int at, output bit seen);
    seen = 1'b0;
    at   = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      if (io.mem_ready) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
  endtask

  task automatic do_req(input bit st, input bit ld, input logic [63:0] addr,
                        input logic [LW-1:0] data);
    bit seen;
    int at;
    @(posedge clock); #1;
    push_expect(st, addr, data, 1'b1);
    io.mem_req_store = st;
    io.mem_req_load  = ld;
    io.mem_addr      = addr;
    tb_drv           = st ? data : rand_line();
    wait_ready(at, seen);
    check("ready_seen", seen, 1'b1);
    @(posedge clock); #1;
    io.mem_req_store = 1'b0;
    io.mem_req_load  = 1'b0;
    tb_drv           = rand_line();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] d;
    logic [63:0]   a;
    bit            st, seen;
    int            r1, r2;

    io.mem_req_store = 1'b0;
    io.mem_req_load  = 1'b0;
    io.mem_addr      = '0;
    tb_drv           = rand_line();

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_bus_req",   io.bus_req,   '0);
    check("rst_bus_we",    io.bus_we,    '0);
    check("rst_bus_addr",  io.bus_addr,  '0);
    check("rst_bus_wdata", io.bus_wdata, '0);
    check("rst_mem_ready", io.mem_ready, '0);
    check("rst_mem_data",  mem_data,     tb_drv);
    reset = 1'b1;

    // Store write-back, beats A/B/C/D at 0x1040..0x1070.
    d = {128'hD, 128'hC, 128'hB, 128'hA};
    do_req(1'b1, 1'b0, 64'h1040, d);

    // Load refill from preloaded memory.
    for (int i = 0; i < BEATS; i++) begin
      bmem[64'h2000 + 64'(i * BB)]    = {16{8'(8'h11 * (i + 1))}};
      ref_mem[64'h2000 + 64'(i * BB)] = {16{8'(8'h11 * (i + 1))}};
    end
    do_req(1'b0, 1'b1, 64'h2000, '0);

    // Two-cycle stall on beat 1 of a load.
    stall_addr = 64'h2010;
    stall_left = 2;
    do_req(1'b0, 1'b1, 64'h2000, '0);

    // Both requests high: store first, then the held load at a new address.
    @(posedge clock); #1;
    d = rand_line();
    push_expect(1'b1, 64'h3000, d, 1'b1);
    io.mem_req_store = 1'b1;
    io.mem_req_load  = 1'b1;
    io.mem_addr      = 64'h3000;
    tb_drv           = d;
    wait_ready(r1, seen);
    check("prio_store_ready", seen, 1'b1);
    @(posedge clock); #1;
    io.mem_req_store = 1'b0;
    io.mem_addr      = 64'h4000;
    tb_drv           = rand_line();
    push_expect(1'b0, 64'h4000, '0, 1'b0);
    wait_ready(r2, seen);
    check("prio_load_ready", seen, 1'b1);
    // RESPOND, TURN, then IDLE samples the load, then BEATS beats.
    check("prio_ready_gap", r2 - r1, BEATS + 3);
    @(posedge clock); #1;
    io.mem_req_load = 1'b0;

    // Unaligned load reads back the line stored at 0x1040.
    do_req(1'b0, 1'b1, 64'h1047, '0);

    // Reset during beat 2 of a load.
    @(posedge clock); #1;
    push_expect(1'b0, 64'h5000, '0, 1'b1);
    io.mem_req_load = 1'b1;
    io.mem_addr     = 64'h5000;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (io.bus_req && io.bus_addr == 64'h5020) seen = 1'b1;
    end
    check("abort_beat2_seen", seen, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("abort_bus_req",   io.bus_req,   '0);
    check("abort_bus_addr",  io.bus_addr,  '0);
    check("abort_mem_ready", io.mem_ready, '0);
    exp_beats.delete();
    exp_resp.delete();
    io.mem_req_load = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    do_req(1'b0, 1'b1, 64'h5000, '0);

    // Randomized traffic over a small set of lines with random bus stalls.
    random_ack = 1'b1;
    for (int n = 0; n < 40; n++) begin
      a  = 64'h8000 + 64'($urandom_range(0, 7)) * 64'(LB) + 64'($urandom_range(0, LB - 1));
      st = 1'(($urandom_range(0, 1)));
      do_req(st, !st, a, st ? rand_line() : '0);
    end
    random_ack = 1'b0;

    repeat (4) @(negedge clock);
    check("beats_outstanding", 32'(exp_beats.size()), 32'd0);
    check("resps_outstanding", 32'(exp_resp.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
